stream_rr_arbiter: RTL

Packet-level round-robin arbiter that shares one downstream ready/valid stream between `N_INPUTS` upstream requesters, typically placed in front of a shared `fifo_ready_valid` instance or a single consumer. A grant is held for a whole packet, delimited by a `last` flag, so beats from different requesters never interleave. Output is registered through a one-entry skid-free slice, with full throughput inside a packet and one arbitration cycle between packets.

---
 rtl/stream_rr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter: N ready/valid requesters share one registered
// output stream; a grant is held from the first beat until the beat carrying last.
module stream_rr_arbiter #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_data_i,
  input  logic [N_INPUTS-1:0]            s_valid_i,
  input  logic [N_INPUTS-1:0]            s_last_i,
  output logic [N_INPUTS-1:0]            s_ready_o,
  output logic [DATA_WIDTH-1:0]          m_data_o,
  output logic                           m_last_o,
  output logic [ID_WIDTH-1:0]            m_id_o,
  output logic                           m_valid_o,
  input  logic                           m_ready_i
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic                    full_q, full_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    last_q, last_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;

  logic [ID_WIDTH-1:0]     pick, idx_w;
  logic                    found;
  logic                    slot_open, xfer, gnt_last;
  logic [DATA_WIDTH-1:0]   gnt_data;

  // The slot can take a beat when empty or when it drains this same cycle.
  assign slot_open = ~full_q | m_ready_i;
  assign gnt_data  = s_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign gnt_last  = s_last_i[grant_q];
  assign xfer      = |(s_ready_o & s_valid_i);

  // First requester at or after rr_ptr, wrapping modulo N_INPUTS.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx_w = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      idx_w = ID_WIDTH'((int'(rr_ptr_q) + i) % N_INPUTS);
      if (!found && s_valid_i[idx_w]) begin
        pick  = idx_w;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|s_valid_i) state_d = LOCKED;
      LOCKED:  if (xfer && gnt_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready only to the granted input; no path from any s_valid_i bit.
  always_comb begin
    s_ready_o = '0;
    if (state_q == LOCKED) s_ready_o[grant_q] = slot_open;
    m_valid_o = full_q;
    m_data_o  = data_q;
    m_last_o  = last_q;
    m_id_o    = id_q;
  end

  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    full_d   = full_q;
    data_d   = data_q;
    last_d   = last_q;
    id_d     = id_q;
    if (state_q == IDLE && |s_valid_i) grant_d = pick;
    if (xfer) begin
      full_d = 1'b1;
      data_d = gnt_data;
      last_d = gnt_last;
      id_d   = grant_q;
      if (gnt_last)
        rr_ptr_d = (grant_q == ID_WIDTH'(N_INPUTS - 1)) ? '0 : grant_q + 1'b1;
    end else if (m_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
      full_q   <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      id_q     <= '0;
    end else begin
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      full_q   <= full_d;
      data_q   <= data_d;
      last_q   <= last_d;
      id_q     <= id_d;
    end
  end

endmodule
